gray_counter: RTL and testbench
===============================

GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 Parameter: WIDTH, default 4, count width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: en  input  1  count enable; advances one step per clk while high.
REQ-005 Port: up  input  1  direction; 1 = increment, 0 = decrement, sampled with en.
REQ-006 Port: load  input  1  synchronous load strobe.
REQ-007 Port: load_val  input  WIDTH  binary value to load when load is high.
REQ-008 Port: G  output  WIDTH  registered Gray-coded count, the direct input of the downstream Gray-to-binary stage.
REQ-009 Port: tc  output  1  terminal count, combinational: high when the next enabled step in the current direction wraps.
REQ-010 Port: wrap  output  1  registered one-cycle pulse marking that the last update wrapped.
REQ-011 Port: valid  output  1  registered one-cycle pulse marking that G changed on the last edge.

Function
REQ-012 The block SHALL hold a WIDTH-bit binary count cnt internally and drive G = cnt ^ (cnt >> 1) from a register, never from combinational logic after the flop.
REQ-013 Update priority per edge SHALL be load > en > hold.
REQ-014 load=1: cnt <= load_val; G <= load_val ^ (load_val >> 1); valid <= 1 only if the new G differs from the old G; wrap <= 0.
REQ-015 load=0, en=1, up=1: cnt <= cnt+1 modulo 2^WIDTH; valid <= 1.
REQ-016 load=0, en=1, up=0: cnt <= cnt-1 modulo 2^WIDTH; valid <= 1.
REQ-017 load=0, en=0: cnt and G SHALL hold; valid <= 0; wrap <= 0.
REQ-018 Up wrap: cnt = 2^WIDTH-1 with en=1, up=1 SHALL go to 0 and set wrap <= 1 for one cycle.
REQ-019 Down wrap: cnt = 0 with en=1, up=0 SHALL go to 2^WIDTH-1 and set wrap <= 1 for one cycle.
REQ-020 tc = en & ~load & ((up & cnt == all-ones) | (~up & cnt == 0)).
REQ-021 Every en-driven step, including both wraps, SHALL change exactly one bit of G.
REQ-022 A direction change between cycles SHALL take effect on the very next step with no extra latency or skipped state.
REQ-023 The latency from an input sampled at edge N to G, wrap and valid SHALL be exactly one clk.
REQ-024 load with en both high SHALL perform the load only; no step is added on that edge.

Reset
REQ-025 rst_n low SHALL immediately, without waiting for clk, force cnt = 0, G = 0, wrap = 0 and valid = 0.
REQ-026 tc during reset SHALL follow REQ-020 with cnt = 0.
REQ-027 Reset asserted mid-count SHALL discard any pending load or step.
REQ-028 After reset deassertion, the first rising edge SHALL act normally per REQ-013..REQ-019.

Verification (WIDTH=4)
REQ-029 Reset, then en=1, up=1 for 16 cycles -> G = 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000 with wrap=1 for one cycle; tc=1 while G=1000.
REQ-030 From G=0000, en=1, up=0 for one cycle -> G=1000 (cnt=15), wrap=1; tc=1 on the preceding cycle.
REQ-031 load=1, en=1, load_val=0110 -> G=0101 after one edge, wrap=0, no extra step.
REQ-032 Count up to G=0110, then pull rst_n low between edges -> G=0000, valid=0 and wrap=0 before the next edge.
REQ-033 en toggled randomly for 200 cycles with random up -> every G change differs by exactly one bit, valid high exactly on the change cycles, G feeding a Gray-to-binary model matches the reference cnt.
REQ-034 en=0 for 5 cycles at G=1101 -> G holds 1101, valid=0, wrap=0, tc=0.

Source files
------------

// File: rtl/gray_counter.sv
// Up/down Gray-code counter with synchronous load, combinational terminal-count,
// and registered wrap/valid pulses. A binary count is kept internally and G is
// re-registered from it so the downstream Gray-to-binary stage sees a clean flop.
module gray_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] G,
   output logic             tc,
   output logic             wrap,
   output logic             valid
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_g;
   logic             r_wrap;
   logic             r_valid;

   logic [WIDTH-1:0] w_step_cnt;
   logic [WIDTH-1:0] w_step_g;
   logic [WIDTH-1:0] w_load_g;
   logic             w_all_ones;
   logic             w_zero;
   logic             w_at_edge;

   assign w_all_ones = &r_cnt;
   assign w_zero     = ~|r_cnt;
   // True when a step in the current direction would cross the modulo boundary.
   assign w_at_edge  = (up & w_all_ones) | (~up & w_zero);

   assign w_step_cnt = up ? (r_cnt + ONE) : (r_cnt - ONE);
   assign w_step_g   = w_step_cnt ^ (w_step_cnt >> 1);
   assign w_load_g   = load_val ^ (load_val >> 1);

   assign tc = en & ~load & w_at_edge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_g     <= '0;
         r_wrap  <= 1'b0;
         r_valid <= 1'b0;
      end else if (load) begin
         // Reloading the current value leaves G unchanged, so no valid pulse.
         r_cnt   <= load_val;
         r_g     <= w_load_g;
         r_valid <= (w_load_g != r_g);
         r_wrap  <= 1'b0;
      end else if (en) begin
         r_cnt   <= w_step_cnt;
         r_g     <= w_step_g;
         r_valid <= 1'b1;
         r_wrap  <= w_at_edge;
      end else begin
         r_valid <= 1'b0;
         r_wrap  <= 1'b0;
      end
   end

   assign G     = r_g;
   assign wrap  = r_wrap;
   assign valid = r_valid;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: directed sequences plus a randomized run
// checked against an arithmetic modulo-counter model.
module tb_gray_counter;

   localparam int W   = 4;
   localparam int MOD = 1 << W;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0;
   logic         up = 1'b1;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] G;
   logic         tc;
   logic         wrap;
   logic         valid;

   int vectors = 0;
   int miscompares = 0;
   int m_cnt = 0;

   // Expected G for a plain up-count from zero (the classic reflected code).
   logic [W-1:0] up_seq [0:15] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                   4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                   4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                   4'b1010, 4'b1011, 4'b1001, 4'b1000};

   gray_counter #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load),
      .load_val(load_val), .G(G), .tc(tc), .wrap(wrap), .valid(valid)
   );

   always #5 clk = ~clk;

   function automatic int gray(input int n);
      return (n ^ (n >> 1)) % MOD;
   endfunction

   // Independent Gray-to-binary decode: bit i is the parity of G[W-1:i].
   function automatic int g2b(input logic [W-1:0] g);
      int b = 0;
      for (int i = 0; i < W; i++) begin
         logic [W-1:0] s;
         s = g >> i;
         if (^s) b = b | (1 << i);
      end
      return b;
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, check tc before the edge, check registered outputs after.
   task automatic cycle(input logic v_en, input logic v_up, input logic v_load,
                        input logic [W-1:0] v_lv);
      logic [W-1:0] prev_g;
      int  exp_tc, exp_wrap, exp_valid, nxt;
      bit  stepped;
      en = v_en; up = v_up; load = v_load; load_val = v_lv;
      #1;
      exp_tc = (v_en && !v_load && ((v_up && m_cnt == MOD-1) || (!v_up && m_cnt == 0))) ? 1 : 0;
      check("tc", int'(tc), exp_tc);
      prev_g  = G;
      stepped = 1'b0;
      if (v_load) begin
         nxt       = int'(v_lv);
         exp_valid = (gray(nxt) != gray(m_cnt)) ? 1 : 0;
         exp_wrap  = 0;
      end else if (v_en) begin
         nxt       = v_up ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
         exp_wrap  = (v_up ? (m_cnt == MOD-1) : (m_cnt == 0)) ? 1 : 0;
         exp_valid = 1;
         stepped   = 1'b1;
      end else begin
         nxt       = m_cnt;
         exp_wrap  = 0;
         exp_valid = 0;
      end
      m_cnt = nxt;
      @(posedge clk);
      #1;
      check("G", int'(G), gray(m_cnt));
      check("g2b", g2b(G), m_cnt);
      check("wrap", int'(wrap), exp_wrap);
      check("valid", int'(valid), exp_valid);
      if (stepped) check("onebit", $countones(G ^ prev_g), 1);
   endtask

   initial begin
      logic [W-1:0] lv;
      // Reset state, with tc following the enable/direction inputs at cnt = 0.
      #2;
      check("rst_G", int'(G), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_wrap", int'(wrap), 0);
      en = 1'b1; up = 1'b0; #1;
      check("rst_tc_down", int'(tc), 1);
      up = 1'b1; #1;
      check("rst_tc_up", int'(tc), 0);
      en = 1'b0;
      @(posedge clk); #1;
      check("rst_hold_G", int'(G), 0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      m_cnt = 0;

      // Full up-count with wrap back to zero.
      for (int i = 1; i <= 16; i++) begin
         cycle(1'b1, 1'b1, 1'b0, '0);
         check("upseq", int'(G), int'(up_seq[i % 16]));
      end

      // Down-wrap from zero.
      cycle(1'b1, 1'b0, 1'b0, '0);
      check("down_wrap_G", int'(G), 4'b1000);

      // Load has priority over enable; no extra step.
      cycle(1'b1, 1'b1, 1'b1, 4'b0110);
      check("load_G", int'(G), 4'b0101);

      // Hold at G=1101 for five cycles.
      cycle(1'b0, 1'b1, 1'b1, 4'b1001);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b0, 1'b1, 1'b0, '0);
         check("hold_G", int'(G), 4'b1101);
      end

      // Reloading the same value must not raise valid.
      cycle(1'b0, 1'b0, 1'b1, 4'b1001);

      // Direction reversal takes effect immediately.
      cycle(1'b1, 1'b1, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b0, 1'b0, '0);

      // Randomized enable/direction with occasional loads.
      for (int i = 0; i < 200; i++) begin
         lv = W'($urandom_range(0, MOD-1));
         cycle(1'(($urandom_range(0, 3)) != 0), 1'($urandom_range(0, 1)),
               1'(($urandom_range(0, 15)) == 0), lv);
      end

      // Asynchronous reset between edges discards a pending load/step.
      cycle(1'b0, 1'b1, 1'b1, 4'b0000);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, '0);
      check("pre_rst_G", int'(G), 4'b0110);
      en = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'b1111;
      #2 rst_n = 1'b0;
      #1;
      check("async_G", int'(G), 0);
      check("async_valid", int'(valid), 0);
      check("async_wrap", int'(wrap), 0);
      load = 1'b0; up = 1'b0; #1;
      check("async_tc", int'(tc), 1);
      @(posedge clk); #1;
      check("rst_discard_G", int'(G), 0);
      #3 rst_n = 1'b1;
      m_cnt = 0;

      // First edges after reset behave normally.
      cycle(1'b1, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b1, 1'b0, '0);
      cycle(1'b1, 1'b1, 1'b0, '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
